// File: rtl/crossing_bypass_fifo_if.sv
// crossing_bypass_fifo_if: handshake bundle between a FIFO and its producer/consumer side.
//   clr     sync clear            enq/d_in  enqueue strobe and data
//   deq     dequeue strobe        d_out     head-of-queue data
//   full_n  1 = space available   empty_n   1 = d_out valid
//   count   entries held (0..2**LOG2DEPTH)
//   master: drives clr/enq/deq/d_in; slave: the FIFO itself
interface crossing_bypass_fifo_if #(
    parameter int WIDTH     = 1,
    parameter int LOG2DEPTH = 2
);
    logic                 clr;
    logic                 enq;
    logic                 deq;
    logic [WIDTH-1:0]     d_in;
    logic [WIDTH-1:0]     d_out;
    logic                 full_n;
    logic                 empty_n;
    logic [LOG2DEPTH:0]   count;
    modport master (output clr, enq, deq, d_in, input d_out, full_n, empty_n, count);
    modport slave  (input clr, enq, deq, d_in, output d_out, full_n, empty_n, count);
endinterface

// File: rtl/crossing_bypass_fifo.sv
// crossing_bypass_fifo: DEPTH-entry single-clock FIFO with optional same-cycle bypass.
//   i_clk  clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    crossing_bypass_fifo_if.slave (clr, enq, d_in, full_n, deq, d_out, empty_n, count)
//   Define CROSSING_BYPASS_EN to add the comb enq->empty_n / d_in->d_out path when empty.
module crossing_bypass_fifo #(
    parameter int WIDTH     = 1,
    parameter int LOG2DEPTH = 2,
    parameter int DEPTH     = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    crossing_bypass_fifo_if.slave      bus
);
    if (DEPTH != (1 << LOG2DEPTH)) begin : g_bad_depth
        $error("crossing_bypass_fifo: DEPTH must equal 2**LOG2DEPTH");
    end
    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [LOG2DEPTH-1:0] r_wr_ptr;
    logic [LOG2DEPTH-1:0] r_rd_ptr;
    logic [LOG2DEPTH:0]   r_count;
    logic [LOG2DEPTH:0]   w_count_nx;
    logic                 r_full_n;
    logic                 r_empty;
    logic                 w_bypass;
    logic                 w_wr;
    logic                 w_rd;
`ifdef CROSSING_BYPASS_EN
    // An enqueue into an empty FIFO is visible at once; a same-cycle dequeue takes it straight through.
    assign w_bypass    = bus.enq & r_empty;
    assign bus.empty_n = ~r_empty | bus.enq;
    assign bus.d_out   = r_empty ? bus.d_in : r_mem[r_rd_ptr];
`else
    assign w_bypass    = 1'b0;
    assign bus.empty_n = ~r_empty;
    assign bus.d_out   = r_mem[r_rd_ptr];
`endif
    // Illegal strobes (enq when full, deq when empty) are simply dropped.
    assign w_wr       = bus.enq & r_full_n & ~bus.clr & ~(w_bypass & bus.deq);
    assign w_rd       = bus.deq & bus.empty_n & ~bus.clr & ~w_bypass;
    assign w_count_nx = r_count + (LOG2DEPTH+1)'(w_wr) - (LOG2DEPTH+1)'(w_rd);
    assign bus.full_n = r_full_n;
    assign bus.count  = r_count;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst || bus.clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full_n <= 1'b1;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= r_wr_ptr + LOG2DEPTH'(w_wr);
            r_rd_ptr <= r_rd_ptr + LOG2DEPTH'(w_rd);
            r_count  <= w_count_nx;
            r_full_n <= w_count_nx != (LOG2DEPTH+1)'(DEPTH);
            r_empty  <= w_count_nx == '0;
        end
    end
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= bus.d_in;
    end
endmodule

// File: tb/tb_crossing_bypass_fifo.sv
// tb_crossing_bypass_fifo: table, hand-written and randomized checks of crossing_bypass_fifo.
module tb_crossing_bypass_fifo;
`ifdef CROSSING_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    crossing_bypass_fifo_if #(.WIDTH(8), .LOG2DEPTH(2)) bus ();
    crossing_bypass_fifo #(.WIDTH(8), .LOG2DEPTH(2), .DEPTH(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );
    int passed = 0;
    int total  = 0;
    logic [7:0] q[$];
    logic [2:0] m_cnt;
    logic       m_fn, m_en, m_dchk;
    logic [7:0] m_dout;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask
    // Apply inputs for one cycle; record the reference view before the edge, then advance the reference.
    task automatic drive(input logic c, input logic e, input logic dq, input logic [7:0] d);
        int pre;
        @(negedge clk);
        bus.clr = c; bus.enq = e; bus.deq = dq; bus.d_in = d;
        #1;
        pre    = q.size();
        m_cnt  = 3'(pre);
        m_fn   = pre != 4;
        m_en   = pre != 0 || (BYP && e);
        m_dchk = pre != 0 || (BYP && e);
        m_dout = pre != 0 ? q[0] : d;
        if (c) q.delete();
        else if (!(BYP && e && dq && pre == 0)) begin
            if (dq && pre > 0) void'(q.pop_front());
            if (e && pre < 4) q.push_back(d);
        end
    endtask
    typedef struct {
        logic       clr, enq, deq;
        logic [7:0] d;
        logic [2:0] cnt;
        logic       fn, en;
        logic [7:0] dout;
        logic       dchk;
    } vec_t;
    vec_t tab[16];
    initial begin
        bus.clr = 0; bus.enq = 0; bus.deq = 0; bus.d_in = 0;
        tab[0]  = '{0, 1, 0, 8'h11, 3'd0, 1, BYP, 8'h11, BYP};
        tab[1]  = '{0, 1, 0, 8'h22, 3'd1, 1, 1,   8'h11, 1};
        tab[2]  = '{0, 1, 0, 8'h33, 3'd2, 1, 1,   8'h11, 1};
        tab[3]  = '{0, 1, 0, 8'h44, 3'd3, 1, 1,   8'h11, 1};
        tab[4]  = '{0, 1, 0, 8'h55, 3'd4, 0, 1,   8'h11, 1};
        tab[5]  = '{0, 0, 0, 8'h00, 3'd4, 0, 1,   8'h11, 1};
        tab[6]  = '{0, 0, 1, 8'h00, 3'd4, 0, 1,   8'h11, 1};
        tab[7]  = '{0, 0, 1, 8'h00, 3'd3, 1, 1,   8'h22, 1};
        tab[8]  = '{0, 0, 1, 8'h00, 3'd2, 1, 1,   8'h33, 1};
        tab[9]  = '{0, 0, 1, 8'h00, 3'd1, 1, 1,   8'h44, 1};
        tab[10] = '{0, 0, 1, 8'h00, 3'd0, 1, 0,   8'h00, 0};
        tab[11] = '{0, 0, 0, 8'h00, 3'd0, 1, 0,   8'h00, 0};
        tab[12] = '{0, 1, 0, 8'h66, 3'd0, 1, BYP, 8'h66, BYP};
        tab[13] = '{0, 1, 0, 8'h77, 3'd1, 1, 1,   8'h66, 1};
        tab[14] = '{1, 1, 0, 8'h88, 3'd2, 1, 1,   8'h66, 1};
        tab[15] = '{0, 0, 0, 8'h00, 3'd0, 1, 0,   8'h00, 0};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_count", 32'(bus.count), 0);
        chk("reset_full_n", 32'(bus.full_n), 1);
        chk("reset_empty_n", 32'(bus.empty_n), 0);
        for (int i = 0; i < 16; i++) begin
            drive(tab[i].clr, tab[i].enq, tab[i].deq, tab[i].d);
            chk($sformatf("tab%0d_count", i), 32'(bus.count), 32'(tab[i].cnt));
            chk($sformatf("tab%0d_full_n", i), 32'(bus.full_n), 32'(tab[i].fn));
            chk($sformatf("tab%0d_empty_n", i), 32'(bus.empty_n), 32'(tab[i].en));
            if (tab[i].dchk) chk($sformatf("tab%0d_d_out", i), 32'(bus.d_out), 32'(tab[i].dout));
        end
        // Wrap: hold two entries while streaming ten words through, crossing the pointer wrap.
        drive(0, 1, 0, 8'd0);
        drive(0, 1, 0, 8'd1);
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 1, 8'(k + 2));
            chk($sformatf("wrap%0d_d_out", k), 32'(bus.d_out), 32'(k));
            chk($sformatf("wrap%0d_count", k), 32'(bus.count), 2);
        end
        drive(0, 0, 1, 8'd0);
        chk("wrap_tail_d_out", 32'(bus.d_out), 10);
        drive(0, 0, 1, 8'd0);
        chk("wrap_last_d_out", 32'(bus.d_out), 11);
        drive(0, 0, 0, 8'd0);
        chk("wrap_drained", 32'(bus.count), 0);
`ifdef CROSSING_BYPASS_EN
        drive(0, 1, 1, 8'hA5);
        chk("byp_empty_n", 32'(bus.empty_n), 1);
        chk("byp_d_out", 32'(bus.d_out), 32'h0A5);
        drive(0, 0, 0, 8'h00);
        chk("byp_count_after", 32'(bus.count), 0);
        chk("byp_empty_after", 32'(bus.empty_n), 0);
`else
        drive(0, 1, 0, 8'hA5);
        chk("nobyp_empty_same", 32'(bus.empty_n), 0);
        drive(0, 1, 0, 8'h5A);
        chk("nobyp_empty_next", 32'(bus.empty_n), 1);
        chk("nobyp_d_out_next", 32'(bus.d_out), 32'h0A5);
        drive(1, 0, 0, 8'h00);
        chk("clr_count_before", 32'(bus.count), 2);
        drive(0, 0, 0, 8'h00);
        chk("clr_count_after", 32'(bus.count), 0);
        chk("clr_empty_after", 32'(bus.empty_n), 0);
`endif
        // Asynchronous reset mid-cycle with three entries held.
        drive(0, 0, 0, 8'h00);
        drive(0, 1, 0, 8'h01);
        drive(0, 1, 0, 8'h02);
        drive(0, 1, 0, 8'h03);
        drive(0, 0, 0, 8'h00);
        chk("pre_rst_count", 32'(bus.count), 3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", 32'(bus.count), 0);
        chk("async_rst_full_n", 32'(bus.full_n), 1);
        chk("async_rst_empty_n", 32'(bus.empty_n), 0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        drive(0, 0, 0, 8'h00);
        chk("post_rst_count", 32'(bus.count), 0);
        chk("post_rst_empty_n", 32'(bus.empty_n), 0);
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 24) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
            chk("rand_count", 32'(bus.count), 32'(m_cnt));
            chk("rand_full_n", 32'(bus.full_n), 32'(m_fn));
            chk("rand_empty_n", 32'(bus.empty_n), 32'(m_en));
            if (m_dchk) chk("rand_d_out", 32'(bus.d_out), 32'(m_dout));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
